// File: rtl/stack_param.sv
// stack_param: LIFO stack held in a circular buffer, with optional overwrite of the oldest word on full.
// PUSH/POP/GET are sampled every clock edge, and their results are registered one cycle later.
module stack_param #(
  parameter  int WIDTH     = 4,
  parameter  int DEPTH     = 5,
  parameter  int OVERWRITE = 1,
  localparam int IW        = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       command,
  input  logic [IW-1:0]    index,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             error,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_e;

  cmd_e             cmd;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wp;
  logic [IW-1:0]    wp_inc;
  logic [IW-1:0]    wp_dec;
  logic [IW-1:0]    get_addr;
  logic             get_ok;
  int               offs;

  assign cmd = cmd_e'(command);

  // Explicit modulo-DEPTH wrap, so non-power-of-two depths need no special handling.
  always_comb begin
    // NOTE: every combinational output is assigned before any conditional override, so no latch is inferred.
    wp_inc = wp + 1'b1;
    wp_dec = wp - 1'b1;
    if (wp == IW'(DEPTH - 1)) wp_inc = '0;
    if (wp == '0)             wp_dec = IW'(DEPTH - 1);
    get_ok = int'(index) < int'(level);
    offs   = int'(wp) - 1 - int'(index);
    if (offs < 0) offs = offs + DEPTH;
    get_addr = IW'(offs);
  end

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the storage is cleared in reset because words must read as zero after reset, which keeps the array out of plain RAM macros.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp         <= '0;
      level      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      // NOTE: all state uses non-blocking assignment, so every read below sees the value from before this edge.
      data_valid <= 1'b0;
      error      <= 1'b0;
      case (cmd)
        CMD_PUSH: begin
          if (!full || OVERWRITE != 0) begin
            mem[wp] <= data_in;
            wp      <= wp_inc;
            if (!full) level <= level + 1'b1;
          end else begin
            error <= 1'b1;
          end
        end
        CMD_POP: begin
          if (!empty) begin
            data_out   <= mem[wp_dec];
            data_valid <= 1'b1;
            wp         <= wp_dec;
            level      <= level - 1'b1;
          end else begin
            error <= 1'b1;
          end
        end
        CMD_GET: begin
          if (get_ok) begin
            data_out   <= mem[get_addr];
            data_valid <= 1'b1;
          end else begin
            error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_param.sv
// Bench for stack_param: three instances (5-deep overwrite, 5-deep reject, 3-deep overwrite) share one stimulus stream.
// A queue-based stack model predicts every output, and directed scenarios also pin the documented values.
module tb_stack_param;

  typedef logic [3:0] word_t;
  typedef word_t word_q [$];

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] GET  = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] command;
  logic [2:0] index;
  word_t      data_in;

  word_t      dout_a, dout_b, dout_c;
  logic       dv_a, dv_b, dv_c;
  logic       err_a, err_b, err_c;
  logic [2:0] lvl_a, lvl_b;
  logic [1:0] lvl_c;
  logic       full_a, full_b, full_c;
  logic       empty_a, empty_b, empty_c;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  word_q qa, qb, qc;
  word_t exp_dout [3];
  bit    exp_dv   [3];
  bit    exp_err  [3];

  stack_param #(.WIDTH(4), .DEPTH(5), .OVERWRITE(1)) u_a (
    .clk(clk), .reset(reset), .command(command), .index(index), .data_in(data_in),
    .data_out(dout_a), .data_valid(dv_a), .error(err_a), .level(lvl_a),
    .full(full_a), .empty(empty_a)
  );

  stack_param #(.WIDTH(4), .DEPTH(5), .OVERWRITE(0)) u_b (
    .clk(clk), .reset(reset), .command(command), .index(index), .data_in(data_in),
    .data_out(dout_b), .data_valid(dv_b), .error(err_b), .level(lvl_b),
    .full(full_b), .empty(empty_b)
  );

  stack_param #(.WIDTH(4), .DEPTH(3), .OVERWRITE(1)) u_c (
    .clk(clk), .reset(reset), .command(command), .index(index[1:0]), .data_in(data_in),
    .data_out(dout_c), .data_valid(dv_c), .error(err_c), .level(lvl_c),
    .full(full_c), .empty(empty_c)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stack model: back of the queue is the top, front is the oldest word.
  function automatic void model_op(inout word_q q, input int depth, input bit ow,
                                   input logic [1:0] c, input int idx, input word_t din,
                                   inout word_t dout, output bit dv, output bit err);
    dv  = 1'b0;
    err = 1'b0;
    case (c)
      PUSH: begin
        if (q.size() < depth) q.push_back(din);
        else if (ow) begin
          void'(q.pop_front());
          q.push_back(din);
        end else err = 1'b1;
      end
      POP: begin
        if (q.size() > 0) begin
          dout = q.pop_back();
          dv   = 1'b1;
        end else err = 1'b1;
      end
      GET: begin
        if (idx < q.size()) begin
          dout = q[q.size() - 1 - idx];
          dv   = 1'b1;
        end else err = 1'b1;
      end
      default: ;
    endcase
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, compare all three instances.
  task automatic cycle(input logic [1:0] c, input int i, input word_t d, input bit rst_low = 1'b0);
    word_t      act_dout  [3];
    logic       act_dv    [3];
    logic       act_err   [3];
    logic [2:0] act_lvl   [3];
    logic       act_full  [3];
    logic       act_empty [3];
    int         exp_lvl   [3];
    int         depth     [3];
    depth   = '{5, 5, 3};
    reset   = ~rst_low;
    command = c;
    index   = 3'(i);
    data_in = d;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_low) begin
      qa.delete();
      qb.delete();
      qc.delete();
      for (int k = 0; k < 3; k++) begin
        exp_dout[k] = '0;
        exp_dv[k]   = 1'b0;
        exp_err[k]  = 1'b0;
      end
    end else begin
      model_op(qa, 5, 1'b1, c, i,     d, exp_dout[0], exp_dv[0], exp_err[0]);
      model_op(qb, 5, 1'b0, c, i,     d, exp_dout[1], exp_dv[1], exp_err[1]);
      model_op(qc, 3, 1'b1, c, i & 3, d, exp_dout[2], exp_dv[2], exp_err[2]);
    end
    exp_lvl   = '{qa.size(), qb.size(), qc.size()};
    act_dout  = '{dout_a, dout_b, dout_c};
    act_dv    = '{dv_a, dv_b, dv_c};
    act_err   = '{err_a, err_b, err_c};
    act_lvl   = '{lvl_a, lvl_b, {1'b0, lvl_c}};
    act_full  = '{full_a, full_b, full_c};
    act_empty = '{empty_a, empty_b, empty_c};
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (act_dout[k] !== exp_dout[k] || act_dv[k] !== exp_dv[k] || act_err[k] !== exp_err[k] ||
          act_lvl[k] !== 3'(exp_lvl[k]) || act_full[k] !== (exp_lvl[k] == depth[k]) ||
          act_empty[k] !== (exp_lvl[k] == 0)) begin
        n_bad++;
        $display("FAIL model cycle%0d inst%0d: got dout=%0d dv=%b err=%b lvl=%0d full=%b empty=%b, want dout=%0d dv=%b err=%b lvl=%0d",
                 cyc, k, act_dout[k], act_dv[k], act_err[k], act_lvl[k], act_full[k], act_empty[k],
                 exp_dout[k], exp_dv[k], exp_err[k], exp_lvl[k]);
      end
    end
  endtask

  task automatic test_reset();
    cycle(PUSH, 0, 4'd9, 1'b1);
    cycle(PUSH, 0, 4'd9, 1'b1);
    n_cmp++;
    if (lvl_a !== 3'd0 || empty_a !== 1'b1 || full_a !== 1'b0 || dout_a !== 4'd0 || dv_a !== 1'b0 || err_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got lvl=%0d empty=%b full=%b dout=%0d dv=%b err=%b, want 0 1 0 0 0 0",
               lvl_a, empty_a, full_a, dout_a, dv_a, err_a);
    end
  endtask

  task automatic test_push_pop();
    cycle(NOP, 0, 4'd0, 1'b1);
    for (int v = 1; v <= 3; v++) cycle(PUSH, 0, 4'(v));
    for (int i = 0; i < 3; i++) begin
      cycle(POP, 0, 4'd0);
      n_cmp++;
      if (dout_a !== 4'(3 - i) || dv_a !== 1'b1 || lvl_a !== 3'(2 - i)) begin
        n_bad++;
        $display("FAIL push_pop%0d: got dout=%0d dv=%b lvl=%0d, want dout=%0d dv=1 lvl=%0d",
                 i, dout_a, dv_a, lvl_a, 3 - i, 2 - i);
      end
    end
    n_cmp++;
    if (empty_a !== 1'b1) begin
      n_bad++;
      $display("FAIL push_pop_empty: got %b want 1", empty_a);
    end
  endtask

  task automatic test_full_overwrite();
    cycle(NOP, 0, 4'd0, 1'b1);
    for (int v = 1; v <= 7; v++) begin
      cycle(PUSH, 0, 4'(v));
      n_cmp++;
      if (err_a !== 1'b0 || full_a !== (v >= 5) || lvl_a !== 3'((v < 5) ? v : 5)) begin
        n_bad++;
        $display("FAIL overwrite_push%0d: got err=%b full=%b lvl=%0d, want err=0 full=%b lvl=%0d",
                 v, err_a, full_a, lvl_a, (v >= 5), (v < 5) ? v : 5);
      end
      if (v == 6) begin
        n_cmp++;
        if (err_b !== 1'b1 || lvl_b !== 3'd5) begin
          n_bad++;
          $display("FAIL reject_push6: got err=%b lvl=%0d, want err=1 lvl=5", err_b, lvl_b);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(POP, 0, 4'd0);
      n_cmp++;
      if (dout_a !== 4'(7 - i) || dv_a !== 1'b1) begin
        n_bad++;
        $display("FAIL overwrite_pop%0d: got dout=%0d dv=%b, want dout=%0d dv=1", i, dout_a, dv_a, 7 - i);
      end
      if (i == 0) begin
        n_cmp++;
        if (dout_b !== 4'd5 || dv_b !== 1'b1) begin
          n_bad++;
          $display("FAIL reject_pop: got dout=%0d dv=%b, want dout=5 dv=1", dout_b, dv_b);
        end
      end
    end
    cycle(POP, 0, 4'd0);
    n_cmp++;
    if (err_a !== 1'b1 || dv_a !== 1'b0 || dout_a !== 4'd3) begin
      n_bad++;
      $display("FAIL pop_empty: got err=%b dv=%b dout=%0d, want err=1 dv=0 dout=3", err_a, dv_a, dout_a);
    end
  endtask

  task automatic test_get();
    int    idx_tbl [4];
    word_t dout_tbl [4];
    bit    dv_tbl  [4];
    idx_tbl  = '{0, 2, 3, 7};
    dout_tbl = '{4'd12, 4'd10, 4'd10, 4'd10};
    dv_tbl   = '{1'b1, 1'b1, 1'b0, 1'b0};
    cycle(NOP, 0, 4'd0, 1'b1);
    for (int v = 10; v <= 12; v++) cycle(PUSH, 0, 4'(v));
    for (int i = 0; i < 4; i++) begin
      cycle(GET, idx_tbl[i], 4'd0);
      n_cmp++;
      if (dout_a !== dout_tbl[i] || dv_a !== dv_tbl[i] || err_a !== !dv_tbl[i] || lvl_a !== 3'd3) begin
        n_bad++;
        $display("FAIL get_idx%0d: got dout=%0d dv=%b err=%b lvl=%0d, want dout=%0d dv=%b err=%b lvl=3",
                 idx_tbl[i], dout_a, dv_a, err_a, lvl_a, dout_tbl[i], dv_tbl[i], !dv_tbl[i]);
      end
    end
  endtask

  task automatic test_wrap();
    cycle(NOP, 0, 4'd0, 1'b1);
    for (int v = 1; v <= 4; v++) cycle(PUSH, 0, 4'(v));
    for (int i = 0; i < 3; i++) begin
      cycle(GET, i, 4'd0);
      n_cmp++;
      if (dout_c !== 4'(4 - i) || dv_c !== 1'b1 || dout_a !== 4'(4 - i)) begin
        n_bad++;
        $display("FAIL wrap_get%0d: got c=%0d dv=%b a=%0d, want %0d", i, dout_c, dv_c, dout_a, 4 - i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(POP, 0, 4'd0);
      n_cmp++;
      if (dout_c !== 4'(4 - i) || dv_c !== 1'b1 || lvl_c !== 2'(2 - i)) begin
        n_bad++;
        $display("FAIL wrap_pop%0d: got dout=%0d dv=%b lvl=%0d, want dout=%0d dv=1 lvl=%0d",
                 i, dout_c, dv_c, lvl_c, 4 - i, 2 - i);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(NOP, 0, 4'd0, 1'b1);
    for (int v = 1; v <= 3; v++) cycle(PUSH, 0, 4'(v));
    cycle(PUSH, 0, 4'd9, 1'b1);
    n_cmp++;
    if (lvl_a !== 3'd0 || empty_a !== 1'b1 || dout_a !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got lvl=%0d empty=%b dout=%0d, want 0 1 0", lvl_a, empty_a, dout_a);
    end
    cycle(POP, 0, 4'd0);
    n_cmp++;
    if (err_a !== 1'b1 || dv_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_pop: got err=%b dv=%b, want err=1 dv=0", err_a, dv_a);
    end
  endtask

  task automatic test_random();
    cycle(NOP, 0, 4'd0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      cycle(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 49) == 0);
    end
  endtask

  initial begin
    reset   = 1'b0;
    command = NOP;
    index   = '0;
    data_in = '0;
    test_reset();
    test_push_pop();
    test_full_overwrite();
    test_get();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_param.md
STACK_PARAM -- requirements
Module: stack_param

Interface
REQ-001 Parameter WIDTH, default 4: data word width in bits, >=1.
REQ-002 Parameter DEPTH, default 5: number of storage words, >=2, not required to be a power of two.
REQ-003 Parameter OVERWRITE, default 1: behaviour of PUSH when full; 1 = discard oldest word, 0 = reject.
REQ-004 Derived IW = max(1, clog2(DEPTH)); LW = clog2(DEPTH+1).
REQ-005 CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 RESET  in  1  reset, synchronous, active-low.
REQ-007 COMMAND  in  2  operation: 00 NOP, 01 PUSH, 10 POP, 11 GET.
REQ-008 INDEX  in  IW  GET depth from top; 0 = top word.
REQ-009 DATA_IN  in  WIDTH  word written by PUSH.
REQ-010 DATA_OUT  out  WIDTH  registered result of POP/GET.
REQ-011 DATA_VALID  out  1  one-cycle pulse; DATA_OUT updated this cycle.
REQ-012 ERROR  out  1  one-cycle pulse; last command illegal and ignored.
REQ-013 LEVEL  out  LW  number of valid words, 0..DEPTH.
REQ-014 FULL  out  1  LEVEL == DEPTH.
REQ-015 EMPTY  out  1  LEVEL == 0.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH words, indexed by write pointer WP (next free slot), all pointer arithmetic modulo DEPTH.
REQ-017 One command SHALL be sampled per rising edge of CLK; results appear one cycle later (latency 1).
REQ-018 NOP: no state change; DATA_VALID=0, ERROR=0, DATA_OUT holds.
REQ-019 PUSH, LEVEL<DEPTH: mem[WP]<=DATA_IN, WP<=WP+1, LEVEL<=LEVEL+1, ERROR=0.
REQ-020 PUSH, FULL, OVERWRITE=1: mem[WP]<=DATA_IN, WP<=WP+1, LEVEL stays DEPTH, oldest word lost, ERROR=0.
REQ-021 PUSH, FULL, OVERWRITE=0: no state change, ERROR=1.
REQ-022 POP, LEVEL>0: DATA_OUT<=mem[WP-1], DATA_VALID=1, WP<=WP-1, LEVEL<=LEVEL-1.
REQ-023 POP, EMPTY: no state change, DATA_OUT holds, DATA_VALID=0, ERROR=1.
REQ-024 GET, INDEX<LEVEL: DATA_OUT<=mem[WP-1-INDEX], DATA_VALID=1, WP/LEVEL/memory unchanged.
REQ-025 GET, INDEX>=LEVEL (including INDEX>=DEPTH): no state change, DATA_OUT holds, DATA_VALID=0, ERROR=1.
REQ-026 PUSH SHALL never assert DATA_VALID; DATA_VALID and ERROR SHALL never be 1 simultaneously.
REQ-027 FULL, EMPTY SHALL be decoded from registered LEVEL only, no combinational path from inputs.
REQ-028 Wrap-around of WP past DEPTH-1 or below 0 SHALL be seamless for any DEPTH, including non-power-of-two.

Reset
REQ-029 RESET low at a rising edge SHALL override any COMMAND: WP=0, LEVEL=0, all memory words=0, DATA_OUT=0, DATA_VALID=0, ERROR=0.
REQ-030 While RESET low: EMPTY=1, FULL=0; no write occurs.
REQ-031 First command honoured is that sampled on the first edge with RESET high.

Verification (WIDTH=4, DEPTH=5, OVERWRITE=1 unless stated)
REQ-032 Reset; PUSH 1,2,3; POP x3 -> DATA_OUT 3,2,1 each with DATA_VALID=1; LEVEL 2,1,0; EMPTY=1 at end.
REQ-033 PUSH 1..7 -> FULL=1 from 5th push, LEVEL=5, ERROR never set; POP x5 -> 7,6,5,4,3; POP again -> ERROR=1, DATA_OUT holds 3.
REQ-034 OVERWRITE=0: PUSH 1..6 -> 6th push ERROR=1, LEVEL=5; POP -> 5.
REQ-035 PUSH 10,11,12; GET 0 -> 12; GET 2 -> 10; GET 3 -> ERROR=1, DATA_OUT holds 10; LEVEL stays 3.
REQ-036 DEPTH=3: PUSH 1..4, GET 0..2 -> 4,3,2 (wrap correct); POP x3 -> 4,3,2.
REQ-037 PUSH 1,2,3; RESET low with COMMAND=PUSH, DATA_IN=9 -> next cycle LEVEL=0, EMPTY=1, DATA_OUT=0; after release, POP -> ERROR=1.
